// File: rtl/icebus_status_frame_rx_if.sv
// ICEboard status-frame receiver bus: UART byte stream in,
// decoded per-motor status update out.
interface icebus_status_frame_rx_if #(
  parameter int N = 8
);
  localparam int MW = (N > 1) ? $clog2(N) : 1;

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_error;
  logic [8*N-1:0]      id;
  logic                upd_valid;
  logic [MW-1:0]       upd_motor;
  logic signed [23:0]  encoder0_position;
  logic signed [23:0]  encoder1_position;
  logic signed [23:0]  displacement;
  logic signed [12:0]  current;
  logic signed [23:0]  duty;
  logic [31:0]         good_frames;
  logic [31:0]         crc_errors;
  logic [31:0]         drop_count;

  modport master (
    output rx_data, rx_valid, rx_error, id,
    input  upd_valid, upd_motor,
    input  encoder0_position, encoder1_position,
    input  displacement, current, duty,
    input  good_frames, crc_errors, drop_count
  );

  modport slave (
    input  rx_data, rx_valid, rx_error, id,
    output upd_valid, upd_motor,
    output encoder0_position, encoder1_position,
    output displacement, current, duty,
    output good_frames, crc_errors, drop_count
  );
endinterface

// File: rtl/icebus_status_frame_rx.sv
// ICEboard status frame parser: header hunt, CRC-16/CCITT-FALSE,
// id table lookup, one update strobe per good frame.
module icebus_status_frame_rx #(
  parameter int NUMBER_OF_MOTORS = 8,
  parameter int CLOCK_FREQ_HZ    = 50_000_000,
  parameter int BAUDRATE         = 1_000_000
) (
  input logic clk,
  input logic reset,
  icebus_status_frame_rx_if.slave bus
);
  localparam int N       = NUMBER_OF_MOTORS;
  localparam int MW      = (N > 1) ? $clog2(N) : 1;
  localparam int TIMEOUT = 20 * CLOCK_FREQ_HZ / BAUDRATE;
  localparam int GW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_HUNT, S_ID, S_PAYLOAD, S_CRC, S_CHECK
  } state_t;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [7:0] hdr_byte(
    input logic [1:0] i
  );
    logic [7:0] r;
    case (i)
      2'd0:    r = 8'hD0;
      2'd1:    r = 8'h0D;
      2'd2:    r = 8'hBE;
      default: r = 8'hEF;
    endcase
    return r;
  endfunction

  state_t          state_q;
  logic [1:0]      hdr_q;
  logic [3:0]      cnt_q;
  logic [15:0]     crc_q;
  logic [15:0]     crc_rx_q;
  logic [111:0]    pay_q;
  logic [7:0]      id_q;
  logic [GW-1:0]   gap_q;
  logic            chk_v_q;
  logic            chk_ok_q;
  logic            chk_hit_q;
  logic [MW-1:0]   chk_idx_q;
  logic            upd_q;
  logic [MW-1:0]   motor_q;
  logic [23:0]     enc0_q;
  logic [23:0]     enc1_q;
  logic [23:0]     disp_q;
  logic [12:0]     cur_q;
  logic [23:0]     duty_q;
  logic [31:0]     good_q;
  logic [31:0]     crcerr_q;
  logic [31:0]     drop_q;

  logic          hit;
  logic [MW-1:0] hit_idx;
  logic          idle;
  logic          past_hdr;
  logic          tmo;
  logic [7:0]    b;
  logic          unused_cur_hi;

  assign b = bus.rx_data;
  assign unused_cur_hi = ^pay_q[39:37];

  // Descending scan so the lowest matching index is left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.id[8*i +: 8] == id_q) begin
        hit     = 1'b1;
        hit_idx = MW'(i);
      end
    end
  end

  assign idle     = (state_q == S_HUNT && hdr_q == 2'd0)
                 || state_q == S_CHECK;
  assign past_hdr = state_q == S_ID
                 || state_q == S_PAYLOAD
                 || state_q == S_CRC;
  assign tmo      = !idle && !bus.rx_valid
                 && gap_q == GW'(TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_HUNT;
      hdr_q     <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      crc_rx_q  <= '0;
      pay_q     <= '0;
      id_q      <= '0;
      gap_q     <= '0;
      chk_v_q   <= 1'b0;
      chk_ok_q  <= 1'b0;
      chk_hit_q <= 1'b0;
      chk_idx_q <= '0;
      upd_q     <= 1'b0;
      motor_q   <= '0;
      enc0_q    <= '0;
      enc1_q    <= '0;
      disp_q    <= '0;
      cur_q     <= '0;
      duty_q    <= '0;
      good_q    <= '0;
      crcerr_q  <= '0;
      drop_q    <= '0;
    end else begin
      upd_q   <= 1'b0;
      chk_v_q <= 1'b0;

      // Commit stage: verdict from CHECK lands one edge later.
      if (chk_v_q) begin
        if (!chk_ok_q) begin
          crcerr_q <= sat_inc(crcerr_q);
        end else if (!chk_hit_q) begin
          drop_q <= sat_inc(drop_q);
        end else begin
          upd_q   <= 1'b1;
          motor_q <= chk_idx_q;
          enc0_q  <= pay_q[111:88];
          enc1_q  <= pay_q[87:64];
          disp_q  <= pay_q[63:40];
          cur_q   <= pay_q[36:24];
          duty_q  <= pay_q[23:0];
          good_q  <= sat_inc(good_q);
        end
      end

      if (bus.rx_valid || idle)
        gap_q <= '0;
      else
        gap_q <= gap_q + GW'(1);

      if (bus.rx_error || tmo) begin
        state_q <= S_HUNT;
        hdr_q   <= '0;
        gap_q   <= '0;
        if (past_hdr)
          drop_q <= sat_inc(drop_q);
      end else begin
        unique case (state_q)
          S_HUNT: if (bus.rx_valid) begin
            if (b == hdr_byte(hdr_q)) begin
              if (hdr_q == 2'd3) begin
                state_q <= S_ID;
                hdr_q   <= '0;
              end else begin
                hdr_q <= hdr_q + 2'd1;
              end
            end else begin
              hdr_q <= (b == 8'hD0) ? 2'd1 : 2'd0;
            end
          end
          S_ID: if (bus.rx_valid) begin
            id_q    <= b;
            crc_q   <= crc_step(16'hFFFF, b);
            cnt_q   <= '0;
            state_q <= S_PAYLOAD;
          end
          S_PAYLOAD: if (bus.rx_valid) begin
            pay_q <= {pay_q[103:0], b};
            crc_q <= crc_step(crc_q, b);
            if (cnt_q == 4'd13) begin
              cnt_q   <= '0;
              state_q <= S_CRC;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_CRC: if (bus.rx_valid) begin
            crc_rx_q <= {crc_rx_q[7:0], b};
            if (cnt_q == 4'd1)
              state_q <= S_CHECK;
            else
              cnt_q <= 4'd1;
          end
          S_CHECK: begin
            chk_v_q   <= 1'b1;
            chk_ok_q  <= crc_rx_q == crc_q;
            chk_hit_q <= hit;
            chk_idx_q <= hit_idx;
            state_q   <= S_HUNT;
            // A byte landing here starts the next header hunt.
            hdr_q <= (bus.rx_valid && b == 8'hD0) ? 2'd1 : 2'd0;
          end
          default: begin
            state_q <= S_HUNT;
            hdr_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.upd_valid         = upd_q;
  assign bus.upd_motor         = motor_q;
  assign bus.encoder0_position = enc0_q;
  assign bus.encoder1_position = enc1_q;
  assign bus.displacement      = disp_q;
  assign bus.current           = cur_q;
  assign bus.duty              = duty_q;
  assign bus.good_frames       = good_q;
  assign bus.crc_errors        = crcerr_q;
  assign bus.drop_count        = drop_q;
endmodule

// File: tb/tb_icebus_status_frame_rx.sv
// Scoreboard bench for icebus_status_frame_rx: frames built and
// CRC'd by a bit-serial reference, results popped by a monitor.
module tb_icebus_status_frame_rx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icebus_status_frame_rx_if #(.N(8)) bif();

  icebus_status_frame_rx #(
    .NUMBER_OF_MOTORS(8),
    .CLOCK_FREQ_HZ(50_000_000),
    .BAUDRATE(1_000_000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  typedef struct {
    int unsigned        cyc;
    logic [2:0]         motor;
    logic signed [23:0] e0;
    logic signed [23:0] e1;
    logic signed [23:0] dp;
    logic signed [12:0] cur;
    logic signed [23:0] du;
  } exp_t;

  exp_t        q[$];
  exp_t        last_exp;
  logic [7:0]  tbl[8];
  int          m_good = 0;
  int          m_crc = 0;
  int          m_drop = 0;
  int unsigned last_acc = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] c = 16'hFFFF;
    logic fb;
    foreach (d[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ d[i][k];
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic int lookup(input logic [7:0] idv);
    for (int i = 0; i < 8; i++)
      if (tbl[i] == idv) return i;
    return -1;
  endfunction

  task automatic load_tbl();
    for (int i = 0; i < 8; i++) bif.id[8*i +: 8] = tbl[i];
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bif.rx_data = b;
    bif.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    bif.rx_valid = 1'b0;
  endtask

  task automatic send_frame(
    input logic [7:0] idv, input logic [23:0] e0,
    input logic [23:0] e1, input logic [23:0] dp,
    input logic [15:0] cu, input logic [23:0] du,
    input bit bad, input int nbytes, input int maxgap
  );
    logic [7:0] body[$];
    logic [7:0] fr[$];
    logic [15:0] c;
    exp_t e;
    int m;
    body = {idv, e0[23:16], e0[15:8], e0[7:0],
            e1[23:16], e1[15:8], e1[7:0],
            dp[23:16], dp[15:8], dp[7:0],
            cu[15:8], cu[7:0],
            du[23:16], du[15:8], du[7:0]};
    c = crc_ref(body);
    if (bad) c[0] = ~c[0];
    fr = {8'hD0, 8'h0D, 8'hBE, 8'hEF};
    foreach (body[i]) fr.push_back(body[i]);
    fr.push_back(c[15:8]);
    fr.push_back(c[7:0]);
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0 && maxgap > 0)
        repeat ($urandom_range(0, maxgap)) @(posedge clk);
      send_byte(fr[i]);
    end
    if (nbytes == 21) begin
      m = lookup(idv);
      if (bad) m_crc++;
      else if (m < 0) m_drop++;
      else begin
        e.cyc = last_acc + 2;
        e.motor = 3'(m);
        e.e0 = e0; e.e1 = e1; e.dp = dp;
        e.cur = cu[12:0];
        e.du = du;
        q.push_back(e);
        m_good++;
      end
    end
  endtask

  task automatic good_frame(input logic [7:0] idv, input int gap);
    send_frame(idv, 24'($urandom), 24'($urandom), 24'($urandom),
               16'($urandom), 24'($urandom), 1'b0, 21, gap);
  endtask

  task automatic settle_check(input string nm);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk({nm, " pending"}, q.size(), 0);
    chk({nm, " good_frames"}, bif.good_frames, m_good);
    chk({nm, " crc_errors"}, bif.crc_errors, m_crc);
    chk({nm, " drop_count"}, bif.drop_count, m_drop);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    last_exp = '{default: '0};
    m_good = 0; m_crc = 0; m_drop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: pop on every strobe, otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bif.upd_valid) begin
        if (q.size() == 0) begin
          chk("unexpected upd_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc, e.cyc);
          chk("upd_motor", bif.upd_motor, e.motor);
          chk("encoder0", bif.encoder0_position, e.e0);
          chk("encoder1", bif.encoder1_position, e.e1);
          chk("displacement", bif.displacement, e.dp);
          chk("current", bif.current, e.cur);
          chk("duty", bif.duty, e.du);
          last_exp = e;
        end
      end else begin
        chk("hold enc0", bif.encoder0_position, last_exp.e0);
        chk("hold current", bif.current, last_exp.cur);
        chk("hold duty", bif.duty, last_exp.du);
      end
    end
  end

  initial begin
    logic [7:0] idv;
    int kind;
    bif.rx_data = '0;
    bif.rx_valid = 1'b0;
    bif.rx_error = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = 8'(i + 1);
    load_tbl();
    last_exp = '{default: '0};
    do_reset();

    @(negedge clk);
    chk("reset upd_valid", bif.upd_valid, 0);
    chk("reset good", bif.good_frames, 0);
    chk("reset crc", bif.crc_errors, 0);
    chk("reset drop", bif.drop_count, 0);
    chk("reset enc1", bif.encoder1_position, 0);

    send_frame(8'd3, 24'h000010, 24'hFFFFF0, 24'h000100,
               16'h1FFF, 24'h7FFFFF, 1'b0, 21, 2);
    settle_check("t1");
    chk("t1 enc1 -16", bif.encoder1_position, -16);
    chk("t1 current -1", bif.current, -1);

    send_frame(8'd3, 24'h000011, 24'h000022, 24'h000033,
               16'h0005, 24'h000066, 1'b1, 21, 1);
    settle_check("t2 bad crc");
    good_frame(8'd5, 1);
    settle_check("t2 recover");

    good_frame(8'h42, 1);
    settle_check("t3 unknown id");

    send_byte(8'hD0);
    good_frame(8'd7, 0);
    settle_check("t4 resync");

    send_frame(8'd2, 24'h1, 24'h2, 24'h3, 16'h4, 24'h5,
               1'b0, 8, 0);
    repeat (1001) @(posedge clk);
    m_drop++;
    good_frame(8'd2, 0);
    settle_check("t5 timeout");

    send_byte(8'hD0); send_byte(8'h0D);
    send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'd1);  send_byte(8'h55);
    @(negedge clk);
    bif.rx_error = 1'b1;
    bif.rx_valid = 1'b1;
    bif.rx_data = 8'h66;
    @(negedge clk);
    bif.rx_error = 1'b0;
    bif.rx_valid = 1'b0;
    m_drop++;
    good_frame(8'd1, 0);
    settle_check("t7 rx_error");

    tbl[6] = 8'd3;
    load_tbl();
    good_frame(8'd3, 0);
    settle_check("t8 dup id");
    tbl[6] = 8'd7;
    load_tbl();

    send_frame(8'd4, 24'h1, 24'h2, 24'h3, 16'h4, 24'h5,
               1'b0, 10, 0);
    do_reset();
    @(negedge clk);
    chk("t6 good after reset", bif.good_frames, 0);
    chk("t6 drop after reset", bif.drop_count, 0);
    chk("t6 enc0 after reset", bif.encoder0_position, 0);
    good_frame(8'd4, 0);
    settle_check("t6 post reset");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          idv = 8'($urandom);
          if (idv == 8'hEF) idv = 8'h00;
          send_byte(idv);
        end
      end
      idv = (kind == 1) ? (8'h40 | 8'($urandom_range(0, 63)))
                        : 8'($urandom_range(1, 8));
      send_frame(idv, 24'($urandom), 24'($urandom),
                 24'($urandom), 16'($urandom), 24'($urandom),
                 kind == 0, 21, ($urandom_range(0, 1) == 0) ? 0 : 3);
    end
    settle_check("random");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
